// File: rtl/regbank_banked_if.sv
// Bus between the decode/ALU/memory stages and the banked register file.
// The master side drives commit controls; the slave side returns register views.
interface regbank_banked_if #(
    parameter int REGISTER_LENGTH = 32,
    parameter int ADDR_WIDTH      = 14,
    parameter int MODE_WIDTH      = 2
) ();
    logic                       enable;
    logic                       should_branch;
    logic [2:0]                 control;
    logic [3:0]                 register_source_A;
    logic [3:0]                 register_source_B;
    logic [3:0]                 register_Dest;
    logic [REGISTER_LENGTH-1:0] ALU_result;
    logic [REGISTER_LENGTH-1:0] data_from_memory;
    logic [REGISTER_LENGTH-1:0] new_SP;
    logic [ADDR_WIDTH-1:0]      new_PC;
    logic [MODE_WIDTH-1:0]      target_mode;
    logic [REGISTER_LENGTH-1:0] read_data_A;
    logic [REGISTER_LENGTH-1:0] read_data_B;
    logic [REGISTER_LENGTH-1:0] current_PC;
    logic [REGISTER_LENGTH-1:0] current_SP;
    logic [REGISTER_LENGTH-1:0] memory_output;
    logic [MODE_WIDTH-1:0]      current_mode;
    logic                       privileged;
    logic                       fault;

    modport master (
        output enable, should_branch, control,
        output register_source_A, register_source_B, register_Dest,
        output ALU_result, data_from_memory, new_SP, new_PC, target_mode,
        input  read_data_A, read_data_B, current_PC, current_SP,
        input  memory_output, current_mode, privileged, fault
    );

    modport slave (
        input  enable, should_branch, control,
        input  register_source_A, register_source_B, register_Dest,
        input  ALU_result, data_from_memory, new_SP, new_PC, target_mode,
        output read_data_A, read_data_B, current_PC, current_SP,
        output memory_output, current_mode, privileged, fault
    );
endinterface

// File: rtl/regbank_banked.sv
// Register file plus PC with SP (R14) and LR (R13) banked per execution mode.
// Supports one-level-per-mode enter/return, forwarded registered reads and a fault pulse.
module regbank_banked #(
    parameter int          DATA_AREA_START = 8192,
    parameter int          REGISTER_LENGTH = 32,
    parameter logic [31:0] MAX_NUMBER      = 32'hffffffff,
    parameter int          ADDR_WIDTH      = 14,
    parameter int          NUM_MODES       = 4,
    parameter int          MODE_WIDTH      = 2
) (
    input logic        clock,
    input logic        reset,
    regbank_banked_if.slave bus
);
    localparam int RL  = REGISTER_LENGTH;
    localparam int PAD = RL - ADDR_WIDTH;
    localparam logic [RL-1:0] DAS = RL'(DATA_AREA_START);
    localparam logic [RL-1:0] MAX = RL'(MAX_NUMBER);

    logic [RL-1:0]         gpr_q [0:12];
    logic [RL-1:0]         gpr_d [0:12];
    logic [RL-1:0]         sp_q  [0:NUM_MODES-1];
    logic [RL-1:0]         sp_d  [0:NUM_MODES-1];
    logic [RL-1:0]         lr_q  [0:NUM_MODES-1];
    logic [RL-1:0]         lr_d  [0:NUM_MODES-1];
    logic [MODE_WIDTH-1:0] sv_q  [0:NUM_MODES-1];
    logic [MODE_WIDTH-1:0] sv_d  [0:NUM_MODES-1];
    logic [RL-1:0]         pc_q, pc_d, pc_seq, wdata;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [RL-1:0]         rda_q, rda_d, rdb_q, rdb_d, mem_view;
    logic                  fault_q, fault_d;
    logic                  rd_bad, tgt_ok;

    assign pc_seq = {{PAD{1'b0}}, bus.new_PC};
    assign rd_bad = bus.register_Dest >= 4'd14;
    assign tgt_ok = (bus.target_mode != '0) &&
                    (int'(bus.target_mode) < NUM_MODES);
    assign wdata  = (bus.control == 3'd3) ? bus.data_from_memory
                                          : bus.ALU_result;

    always_comb begin
        gpr_d   = gpr_q;
        sp_d    = sp_q;
        lr_d    = lr_q;
        sv_d    = sv_q;
        pc_d    = pc_q;
        mode_d  = mode_q;
        fault_d = 1'b0;
        if (bus.enable) begin
            pc_d = bus.should_branch ? bus.ALU_result : pc_seq;
            sp_d[mode_q] = bus.new_SP;
            unique case (bus.control)
                3'd1, 3'd3: begin
                    if (rd_bad)
                        fault_d = 1'b1;
                    else if (bus.register_Dest == 4'd13)
                        lr_d[mode_q] = wdata;
                    else
                        gpr_d[bus.register_Dest] = wdata;
                end
                3'd2: begin
                    gpr_d[0]     = DAS;
                    sp_d[mode_q] = MAX;
                end
                3'd4: begin
                    if (tgt_ok) begin
                        lr_d[bus.target_mode] = pc_q;
                        sv_d[bus.target_mode] = mode_q;
                        mode_d = bus.target_mode;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                3'd5: begin
                    if (mode_q != '0) begin
                        pc_d   = lr_q[mode_q];
                        mode_d = sv_q[mode_q];
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read ports see the post-edge state, so a same-edge write is forwarded.
    always_comb begin
        rda_d = gpr_d[0];
        case (bus.register_source_A)
            4'd15:   rda_d = pc_d;
            4'd14:   rda_d = sp_d[mode_d];
            4'd13:   rda_d = lr_d[mode_d];
            default: rda_d = gpr_d[bus.register_source_A];
        endcase
        rdb_d = gpr_d[0];
        case (bus.register_source_B)
            4'd15:   rdb_d = pc_d;
            4'd14:   rdb_d = sp_d[mode_d];
            4'd13:   rdb_d = lr_d[mode_d];
            default: rdb_d = gpr_d[bus.register_source_B];
        endcase
        mem_view = gpr_q[0];
        case (bus.register_Dest)
            4'd15:   mem_view = pc_q;
            4'd14:   mem_view = sp_q[mode_q];
            4'd13:   mem_view = lr_q[mode_q];
            default: mem_view = gpr_q[bus.register_Dest];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            gpr_q[0] <= DAS;
            pc_q     <= pc_seq;
            for (int i = 0; i < NUM_MODES; i++) begin
                sp_q[i] <= MAX;
                lr_q[i] <= '0;
                sv_q[i] <= '0;
            end
            mode_q  <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            gpr_q   <= gpr_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            lr_q    <= lr_d;
            sv_q    <= sv_d;
            mode_q  <= mode_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            fault_q <= fault_d;
        end
    end

    assign bus.read_data_A   = rda_q;
    assign bus.read_data_B   = rdb_q;
    assign bus.current_PC    = pc_q;
    assign bus.current_SP    = sp_q[mode_q];
    assign bus.memory_output = mem_view;
    assign bus.current_mode  = mode_q;
    assign bus.privileged    = (mode_q != '0);
    assign bus.fault         = fault_q;
endmodule
